// File: rtl/acc_requant.sv
// Accumulate a packet of signed 16-bit products, add bias, then round, shift, ReLU and saturate
// the sum to signed 8-bit. Valid/ready handshake on both the product and the result side.
module acc_requant #(
  parameter int ACC_W = 32,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [15:0]      in_prod,
  input  logic [ACC_W-1:0] bias,
  input  logic [SH_W-1:0]  shift,
  input  logic             relu_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sat,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {IDLE, ACC, QUANT, OUT} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [SH_W-1:0]    shift_q, shift_d;
  logic               relu_q, relu_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;

  logic               beat_ok;
  logic [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W:0] acc_ext, rnd_w, sum_w, shifted_w, q_w;
  logic               pos_ovf, neg_ovf;
  logic [7:0]         res8;

  assign beat_ok  = in_valid && in_ready;
  assign prod_ext = {{(ACC_W-16){in_prod[15]}}, in_prod};

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: begin
        if (beat_ok) begin
          if (in_first)                       state_d = in_last ? QUANT : ACC;
          else if (state_q == ACC && in_last) state_d = QUANT;
        end
      end
      QUANT:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == ACC);
  end

  // Requantisation: one extra bit so the rounding add can never overflow.
  always_comb begin
    acc_ext   = {acc_q[ACC_W-1], acc_q};
    rnd_w     = (shift_q == '0) ? '0 : ((ACC_W+1)'(1) << (shift_q - SH_W'(1)));
    sum_w     = acc_ext + rnd_w;
    shifted_w = sum_w >>> shift_q;
    q_w       = (relu_q && shifted_w[ACC_W]) ? '0 : shifted_w;
    pos_ovf   = !q_w[ACC_W] && (|q_w[ACC_W-1:7]);
    neg_ovf   = q_w[ACC_W] && !(&q_w[ACC_W-1:7]);
    res8      = pos_ovf ? 8'h7F : (neg_ovf ? 8'h80 : q_w[7:0]);
  end

  // Datapath next-state
  always_comb begin
    acc_d       = acc_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    err_d       = err_clr ? 1'b0 : err_q;
    case (state_q)
      IDLE, ACC: begin
        if (beat_ok) begin
          if (in_first) begin
            // A first beat inside a packet discards the partial sum and restarts.
            acc_d   = bias + prod_ext;
            shift_d = shift;
            relu_d  = relu_en;
            if (state_q == ACC) err_d = 1'b1;
          end else if (state_q == ACC) begin
            acc_d = acc_q + prod_ext;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      QUANT: begin
        out_data_d  = res8;
        out_sat_d   = pos_ovf || neg_ovf;
        out_valid_d = 1'b1;
      end
      OUT: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign err       = err_q;

endmodule

// File: tb/tb_acc_requant.sv
// Bench for acc_requant: directed packets push expected {sat,data} into a scoreboard queue;
// a monitor pops and compares on every output handshake.
module tb_acc_requant;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, in_first, in_last;
  logic [15:0] in_prod;
  logic [31:0] bias;
  logic [4:0]  shift;
  logic        relu_en;
  logic        out_valid, out_ready, out_sat, err, err_clr;
  logic [7:0]  out_data;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb[$];

  acc_requant dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_prod(in_prod), .bias(bias), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Monitor: the handshake completes on the next rising edge
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      logic [8:0] exp_v;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got data=%0d sat=%0b, required no output",
                 $signed(out_data), out_sat);
      end else begin
        exp_v = sb.pop_front();
        if ({out_sat, out_data} !== exp_v) begin
          errors++;
          $display("FAIL result got data=%0d sat=%0b, required data=%0d sat=%0b",
                   $signed(out_data), out_sat, $signed(exp_v[7:0]), exp_v[8]);
        end else
          $display("result data=%0d sat=%0b ok", $signed(out_data), out_sat);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h, required %0h", name, act, req);
    end else
      $display("check %s = %0h ok", name, act);
  endtask

  task automatic expect_out(input logic signed [7:0] d, input logic s);
    sb.push_back({s, d});
  endtask

  // Drive one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic beat(input logic f, input logic l, input logic signed [15:0] p,
                      input logic [31:0] b, input logic [4:0] sh, input logic r);
    int n = 0;
    in_valid = 1'b1; in_first = f; in_last = l; in_prod = p;
    bias = b; shift = sh; relu_en = r;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_timeout in_ready=0 after 50 cycles, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic t1_packet();
    expect_out(8'sd65, 1'b0);
    beat(1, 0, 16'sd100, 32'd10, 5'd2, 0);
    beat(0, 0, 16'sd200, 32'd0, 5'd0, 0);
    beat(0, 1, -16'sd50, 32'd0, 5'd0, 0);
  endtask

  initial begin
    logic [7:0] held;
    rstn = 1'b0; in_valid = 0; in_first = 0; in_last = 0; in_prod = '0;
    bias = '0; shift = '0; relu_en = 0; out_ready = 1; err_clr = 0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // T1 plus latency: QUANT cycle, then output valid
    t1_packet();
    chk("t1_quant_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_quant_in_ready", {31'd0, in_ready}, 32'd0);
    cycles(1);
    chk("t1_lat_valid", {31'd0, out_valid}, 32'd1);
    cycles(1);
    chk("t1_done_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_idle_in_ready", {31'd0, in_ready}, 32'd1);

    // T2 saturation both ways
    expect_out(8'sd127, 1'b1);
    beat(1, 0, 16'sd16000, 32'd0, 5'd0, 0);
    repeat (2) beat(0, 0, 16'sd16000, 32'd0, 5'd0, 0);
    beat(0, 1, 16'sd16000, 32'd0, 5'd0, 0);
    expect_out(-8'sd128, 1'b1);
    beat(1, 0, -16'sd16000, 32'd0, 5'd0, 0);
    repeat (2) beat(0, 0, -16'sd16000, 32'd0, 5'd0, 0);
    beat(0, 1, -16'sd16000, 32'd0, 5'd0, 0);

    // T3 ReLU clamp is not saturation; single-beat packets
    expect_out(8'sd0, 1'b0);
    beat(1, 1, -16'sd40, 32'd0, 5'd0, 1);
    expect_out(-8'sd40, 1'b0);
    beat(1, 1, -16'sd40, 32'd0, 5'd0, 0);

    // Rounding add must not overflow; accumulator wraps silently
    expect_out(8'sd1, 1'b0);
    beat(1, 1, 16'sd0, 32'h7FFF_FFFF, 5'd31, 0);
    expect_out(-8'sd1, 1'b0);
    beat(1, 0, 16'sd0, 32'h7FFF_FFFF, 5'd31, 0);
    beat(0, 1, 16'sd1, 32'd0, 5'd0, 0);
    cycles(3);

    // T4 output stall: 5+30-11=24, +1 >>> 1 = 12
    out_ready = 1'b0;
    expect_out(8'sd12, 1'b0);
    beat(1, 0, 16'sd30, 32'd5, 5'd1, 0);
    beat(0, 1, -16'sd11, 32'd0, 5'd0, 0);
    cycles(1);
    held = out_data;
    chk("t4_stall_data", {24'd0, held}, 32'd12);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_prod = 16'sd99;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_data", {24'd0, out_data}, {24'd0, held});
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    cycles(1);
    chk("t4_released_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_no_err", {31'd0, err}, 32'd0);

    // T5 protocol errors, set beats clear on same cycle
    beat(0, 1, 16'sd5, 32'd0, 5'd0, 0);
    chk("t5_err_idle", {31'd0, err}, 32'd1);
    chk("t5_dropped", {31'd0, out_valid}, 32'd0);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    chk("t5_err_clr", {31'd0, err}, 32'd0);
    err_clr = 1'b1;
    beat(0, 0, 16'sd5, 32'd0, 5'd0, 0);
    err_clr = 1'b0;
    chk("t5_set_wins", {31'd0, err}, 32'd1);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    expect_out(8'sd12, 1'b0);
    beat(1, 0, 16'sd50, 32'd0, 5'd0, 0);
    beat(1, 0, 16'sd7, 32'd3, 5'd0, 0);
    chk("t5_err_restart", {31'd0, err}, 32'd1);
    beat(0, 1, 16'sd2, 32'd0, 5'd0, 0);
    cycles(3);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    chk("t5_err_clr2", {31'd0, err}, 32'd0);

    // T6 reset mid-ACC, then mid-OUT
    beat(0, 0, 16'sd1, 32'd0, 5'd0, 0);
    beat(1, 0, 16'sd100, 32'd10, 5'd2, 0);
    #2 rstn = 1'b0; #1;
    chk("t6_acc_rst_err", {31'd0, err}, 32'd0);
    chk("t6_acc_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    out_ready = 1'b0;
    beat(1, 1, 16'sd70, 32'd0, 5'd0, 0);
    cycles(2);
    chk("t6_out_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rstn = 1'b0; #1;
    chk("t6_out_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_out_rst_data", {24'd0, out_data}, 32'd0);
    chk("t6_out_rst_sat", {31'd0, out_sat}, 32'd0);
    @(posedge clk); #1; rstn = 1'b1; out_ready = 1'b1;
    t1_packet();
    cycles(4);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
